// File: rtl/tetris_board_engine.sv
// Tetris board-state engine: merges locked pieces into the settled board,
// collapses full rows one at a time and keeps the saturating score and game-over flag.
module tetris_board_engine #(
    parameter int COLS    = 10,
    parameter int ROWS    = 20,
    parameter int CW      = 8,
    parameter int SCORE_W = 16,
    parameter int SCORE1  = 40,
    parameter int SCORE2  = 100,
    parameter int SCORE3  = 300,
    parameter int SCORE4  = 1200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 E,
    input  logic                 clr,
    input  logic                 lock_valid,
    output logic                 lock_ready,
    input  logic [CW-1:0]        cell0,
    input  logic [CW-1:0]        cell1,
    input  logic [CW-1:0]        cell2,
    input  logic [CW-1:0]        cell3,
    output logic [COLS*ROWS-1:0] board,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           lines_cleared,
    output logic [SCORE_W-1:0]   score,
    output logic                 game_over
);

    localparam int NCELL = COLS * ROWS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [32:0] SCORE_MAX = (33'd1 << SCORE_W) - 33'd1;

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t               state_r;
    logic [RW-1:0]        row_r;
    logic [2:0]           cnt_r;
    logic [NCELL-1:0]     board_r;
    logic [SCORE_W-1:0]   score_r;
    logic [2:0]           lines_r;
    logic                 go_r;
    logic                 done_r;

    logic [NCELL-1:0]     piece_mask_s;
    logic [NCELL-1:0]     shifted_s;
    logic                 overlap_s;
    logic                 row_full_s;

    // One-hot mask of a single cell; out-of-range indices produce an empty mask.
    function automatic logic [NCELL-1:0] cell_mask(input logic [CW-1:0] c);
        logic [NCELL-1:0] m;
        m = '0;
        for (int i = 0; i < NCELL; i++) begin
            if (c == CW'(i)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] points(input logic [2:0] n);
        case (n)
            3'd1:    points = 32'(SCORE1);
            3'd2:    points = 32'(SCORE2);
            3'd3:    points = 32'(SCORE3);
            3'd4:    points = 32'(SCORE4);
            default: points = 32'd0;
        endcase
    endfunction

    // Wide sum so that a large bonus on a narrow score register clamps instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s, input logic [2:0] n);
        logic [32:0] sum;
        sum = 33'(s) + {1'b0, points(n)};
        if (sum > SCORE_MAX) begin
            sat_add = SCORE_MAX[SCORE_W-1:0];
        end else begin
            sat_add = sum[SCORE_W-1:0];
        end
    endfunction

    // Piece footprint and collision against the settled board.
    always_comb begin
        piece_mask_s = cell_mask(cell0) | cell_mask(cell1) | cell_mask(cell2) | cell_mask(cell3);
        overlap_s    = |(piece_mask_s & board_r);
    end

    // Fullness of the row under the scan pointer.
    always_comb begin
        row_full_s = &board_r[int'(row_r)*COLS +: COLS];
    end

    // Board with row_r removed: everything above it drops one row, top row empties.
    always_comb begin
        shifted_s = board_r;
        for (int k = 0; k < ROWS; k++) begin
            if (k == 0) begin
                shifted_s[0 +: COLS] = '0;
            end else if (k <= int'(row_r)) begin
                shifted_s[k*COLS +: COLS] = board_r[(k-1)*COLS +: COLS];
            end else begin
                shifted_s[k*COLS +: COLS] = board_r[k*COLS +: COLS];
            end
        end
    end

    // Lock / scan / shift / score sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            row_r   <= RW'(ROWS-1);
            cnt_r   <= 3'd0;
            board_r <= '0;
            score_r <= '0;
            lines_r <= 3'd0;
            go_r    <= 1'b0;
            done_r  <= 1'b0;
        end else if (E) begin
            if (clr) begin
                state_r <= IDLE;
                row_r   <= RW'(ROWS-1);
                cnt_r   <= 3'd0;
                board_r <= '0;
                score_r <= '0;
                lines_r <= 3'd0;
                go_r    <= 1'b0;
                done_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        done_r <= 1'b0;
                        if (lock_valid && !go_r) begin
                            board_r <= board_r | piece_mask_s;
                            if (overlap_s) begin
                                go_r <= 1'b1;
                            end
                            cnt_r   <= 3'd0;
                            row_r   <= RW'(ROWS-1);
                            state_r <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (row_full_s) begin
                            state_r <= SHIFT;
                        end else if (row_r == '0) begin
                            // Results are latched on entry so they are visible alongside done.
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            lines_r <= cnt_r;
                            score_r <= sat_add(score_r, cnt_r);
                        end else begin
                            row_r <= row_r - RW'(1);
                        end
                    end
                    SHIFT: begin
                        board_r <= shifted_s;
                        cnt_r   <= (cnt_r >= 3'd4) ? 3'd4 : cnt_r + 3'd1;
                        state_r <= SCAN;
                    end
                    DONE: begin
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign board         = board_r;
    assign score         = score_r;
    assign lines_cleared = lines_r;
    assign game_over     = go_r;
    assign done          = done_r;
    assign busy          = (state_r != IDLE);
    assign lock_ready    = (state_r == IDLE) && !go_r;

endmodule

// File: doc/tetris_board_engine.md
Name: tetris_board_engine

Overview:
- Parametrised board-state engine for the Tetris game: owns the settled-block board, merges a locked tetromino into it, detects and collapses full rows, and updates score and game-over status.
- Sits between the piece logic and the board renderer.
  - Upstream: the piece logic hands over the four cells of a landed piece.
  - Downstream: the renderer reads the flat board vector.
- Board dimensions and scoring are generics, so the board can be resized without changing the engine.

Parameters:
- COLS, 10, board columns.
- ROWS, 20, board rows; row 0 is the top.
- CW, 8, cell-index width; must satisfy 2^CW >= COLS*ROWS.
- SCORE_W, 16, score register width.
- SCORE1, 40, points for 1 line cleared in one lock.
- SCORE2, 100, points for 2 lines.
- SCORE3, 300, points for 3 lines.
- SCORE4, 1200, points for 4 lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- E  in  1  enable; when 0, the FSM and all registers hold.
- clr  in  1  synchronous new-game clear.
- lock_valid  in  1  piece-lock request.
- lock_ready  out  1  engine can accept a lock.
- cell0, cell1, cell2, cell3  in  CW each  board index of each piece cell, computed as row*COLS+col.
- board  out  COLS*ROWS  settled cells; bit row*COLS+col.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when lock processing ends.
- lines_cleared  out  3  rows cleared by the last lock (0..4).
- score  out  SCORE_W  accumulated score.
- game_over  out  1  sticky overlap flag.

Behaviour:
- Reset (rst=0, asynchronous): board=0, score=0, lines_cleared=0, game_over=0, done=0, FSM=IDLE, row pointer=ROWS-1, internal line count=0. A reset asserted mid-operation aborts immediately with no partial score update.
- All state changes below require E=1. With E=0, every register holds and done stays at its current value.
- clr=1 (with E=1), in any state: next cycle board=0, score=0, lines_cleared=0, game_over=0, FSM=IDLE. clr takes priority over lock_valid.
- lock_ready = (FSM==IDLE) && !game_over.
- A lock is accepted on the edge where lock_valid && lock_ready && E.
- IDLE, on accept:
  - Each cell index < COLS*ROWS is OR-ed into board. Indices >= COLS*ROWS are ignored.
  - If any in-range cell was already set, game_over<=1. The board is still merged.
  - Line count <= 0, row pointer <= ROWS-1, next state SCAN.
- SCAN (one row per cycle):
  - If row r is all ones, go to SHIFT.
  - Otherwise, if r==0, go to DONE.
  - Otherwise r<=r-1 and stay in SCAN.
- SHIFT (one cycle):
  - For k=r down to 1, row k <= row k-1; row 0 <= 0.
  - Line count += 1.
  - Return to SCAN with r unchanged, so the same row is rechecked.
- DONE (one cycle):
  - done=1 and lines_cleared <= line count.
  - score <= score + SCOREn, where n is the line count; add 0 if n=0.
  - score saturates at 2^SCORE_W-1 and never wraps.
  - Next state IDLE.
- done is registered and high only during the DONE cycle.
- Latency: a lock accepted at edge t with no clears gives done high in cycle t+ROWS+1. Each cleared row adds 2 cycles (SHIFT plus rescan).
- Line count saturates at 4. Counts above 4 cannot arise from a legal tetromino, but the saturation is still required.
- lock_valid during busy is ignored and is not queued.
- While game_over=1, further locks are blocked; only clr or rst recovers.

Test Plan:
- Reset, then lock cells 190, 191, 192, 193 -> board bits 190..193 = 1, done pulses exactly 21 cycles after accept, lines_cleared=0, score=0, busy high for 21 cycles.
- Lock 194..197, then lock 198, 199, 188, 189 -> row 19 clears; board bits 198 and 199 = 1 (moved down from 188 and 189), all other bits 0; lines_cleared=1, score=40, done 23 cycles after accept.
- Prefill rows 16..19 except column 9, then lock the vertical I piece 169, 179, 189, 199 -> lines_cleared=4, board=0, score increases by 1200, done at ROWS+1+8 = 29 cycles.
- Lock a piece overlapping a set cell (e.g. 190 again) -> game_over=1, lock_ready=0; a further lock_valid is ignored; clr -> board=0, score=0, game_over=0, lock_ready=1.
- Hold E=0 for 5 cycles mid-SCAN -> done is delayed by exactly 5 cycles, final board and score unchanged.
- Assert rst=0 during SHIFT -> all outputs read 0 immediately, with no clk edge needed; FSM restarts in IDLE with lock_ready=1.
- With SCORE_W=6 and score=60, clear 1 line -> score saturates at 63.
